// File: rtl/axi_ram_bist_pkg.sv
// Shared definitions for the AXI RAM init/self-test sequencer: command modes,
// controller states and the AXI 4 KB burst boundary.
package axi_ram_bist_pkg;

  localparam logic [1:0] MODE_FILL       = 2'd0;
  localparam logic [1:0] MODE_CHECK      = 2'd1;
  localparam logic [1:0] MODE_FILL_CHECK = 2'd2;

  localparam logic [12:0] BOUNDARY_4K = 13'h1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/axi_ram_bist_ctrl_len_calc.sv
// Burst length for the next INCR burst: the smallest of the remaining words,
// MAX_BURST and the words left before the next 4 KB boundary.
module axi_burst_len_calc
  import axi_ram_bist_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int COUNT_WIDTH = 16,
  parameter int MAX_BURST   = 16,
  parameter int BYTE_SHIFT  = 2
) (
  input  logic [ADDR_WIDTH-1:0]  i_addr,
  input  logic [COUNT_WIDTH-1:0] i_remaining,
  output logic [8:0]             o_len
);

  logic [11:0] w_off;
  logic [12:0] w_room;
  logic [31:0] w_min;

  always_comb begin
    w_off  = 12'(i_addr);
    w_room = (BOUNDARY_4K - {1'b0, w_off}) >> BYTE_SHIFT;
    w_min  = 32'(i_remaining);
    if (32'(w_room) < w_min) w_min = 32'(w_room);
    if (32'(MAX_BURST) < w_min) w_min = 32'(MAX_BURST);
    o_len = 9'(w_min);
  end

endmodule

// File: rtl/axi_ram_bist_ctrl.sv
// AXI4 master that fills a RAM region with an incrementing pattern and/or
// reads it back for comparison, one INCR burst outstanding at a time.
module axi_ram_bist_ctrl
  import axi_ram_bist_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int MAX_BURST   = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [COUNT_WIDTH-1:0] word_count,
  input  logic [DATA_WIDTH-1:0]  pattern,
  output logic                   busy,
  output logic                   done,
  output logic                   fail,
  output logic [ADDR_WIDTH-1:0]  fail_addr,
  output logic [ADDR_WIDTH-1:0]  m_axi_awaddr,
  output logic [7:0]             m_axi_awlen,
  output logic                   m_axi_awvalid,
  input  logic                   m_axi_awready,
  output logic [DATA_WIDTH-1:0]  m_axi_wdata,
  output logic                   m_axi_wlast,
  output logic                   m_axi_wvalid,
  input  logic                   m_axi_wready,
  input  logic                   m_axi_bvalid,
  output logic                   m_axi_bready,
  output logic [ADDR_WIDTH-1:0]  m_axi_araddr,
  output logic [7:0]             m_axi_arlen,
  output logic                   m_axi_arvalid,
  input  logic                   m_axi_arready,
  input  logic [DATA_WIDTH-1:0]  m_axi_rdata,
  input  logic                   m_axi_rlast,
  input  logic                   m_axi_rvalid,
  output logic                   m_axi_rready
);

  localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);

  state_t                 r_state, w_next;
  logic                   r_chk_after, r_fail;
  logic [ADDR_WIDTH-1:0]  r_base, r_addr, r_fail_addr;
  logic [COUNT_WIDTH-1:0] r_count, r_rem;
  logic [DATA_WIDTH-1:0]  r_pattern, r_k;
  logic [7:0]             r_axlen, r_beat;

  logic [ADDR_WIDTH-1:0]  w_base_in, w_step, w_beat_addr, w_calc_addr;
  logic [COUNT_WIDTH-1:0] w_rem_next, w_calc_rem;
  logic [8:0]             w_len, w_len_cur;
  logic [DATA_WIDTH-1:0]  w_expect;
  logic                   w_mismatch;

  assign w_base_in   = (base_addr >> BYTE_SHIFT) << BYTE_SHIFT;
  assign w_len_cur   = {1'b0, r_axlen} + 9'd1;
  assign w_rem_next  = r_rem - COUNT_WIDTH'(w_len_cur);
  assign w_step      = ADDR_WIDTH'(w_len_cur) << BYTE_SHIFT;
  assign w_beat_addr = r_addr + (ADDR_WIDTH'(r_beat) << BYTE_SHIFT);
  assign w_expect    = r_pattern + r_k;
  assign w_mismatch  = (m_axi_rdata != w_expect);

  // Next-burst inputs: fresh command in IDLE, restart from base when the
  // fill phase of FILL_CHECK completes, otherwise continue after this burst.
  always_comb begin
    w_calc_addr = r_addr + w_step;
    w_calc_rem  = w_rem_next;
    if (r_state == ST_IDLE) begin
      w_calc_addr = w_base_in;
      w_calc_rem  = word_count;
    end else if ((r_state == ST_WR_RESP) && (w_rem_next == '0)) begin
      w_calc_addr = r_base;
      w_calc_rem  = r_count;
    end
  end

  axi_burst_len_calc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .COUNT_WIDTH(COUNT_WIDTH),
    .MAX_BURST  (MAX_BURST),
    .BYTE_SHIFT (BYTE_SHIFT)
  ) u_len_calc (
    .i_addr     (w_calc_addr),
    .i_remaining(w_calc_rem),
    .o_len      (w_len)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    busy          = 1'b0;
    done          = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (word_count == '0)      w_next = ST_FINISH;
          else if (mode == MODE_CHECK) w_next = ST_RD_ADDR;
          else                        w_next = ST_WR_ADDR;
        end
      end
      ST_WR_ADDR: begin
        busy          = 1'b1;
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) w_next = ST_WR_DATA;
      end
      ST_WR_DATA: begin
        busy         = 1'b1;
        m_axi_wvalid = 1'b1;
        m_axi_wlast  = (r_beat == r_axlen);
        if (m_axi_wready && (r_beat == r_axlen)) w_next = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        busy         = 1'b1;
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          if (w_rem_next != '0) w_next = ST_WR_ADDR;
          else if (r_chk_after)  w_next = ST_RD_ADDR;
          else                   w_next = ST_FINISH;
        end
      end
      ST_RD_ADDR: begin
        busy          = 1'b1;
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) w_next = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        busy         = 1'b1;
        m_axi_rready = 1'b1;
        if (m_axi_rvalid && m_axi_rlast) begin
          if ((w_rem_next != '0) && !(r_fail || w_mismatch)) w_next = ST_RD_ADDR;
          else                                              w_next = ST_FINISH;
        end
      end
      ST_FINISH: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chk_after <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_base      <= '0;
      r_addr      <= '0;
      r_count     <= '0;
      r_rem       <= '0;
      r_pattern   <= '0;
      r_k         <= '0;
      r_axlen     <= '0;
      r_beat      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_chk_after <= (mode == MODE_FILL_CHECK) || (mode == 2'd3);
            r_base      <= w_base_in;
            r_addr      <= w_base_in;
            r_count     <= word_count;
            r_rem       <= word_count;
            r_pattern   <= pattern;
            r_k         <= '0;
            r_beat      <= '0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            if (word_count != '0) r_axlen <= 8'(w_len - 9'd1);
          end
        end
        ST_WR_DATA: begin
          if (m_axi_wready) begin
            r_beat <= r_beat + 8'd1;
            r_k    <= r_k + 1'b1;
          end
        end
        ST_WR_RESP: begin
          if (m_axi_bvalid) begin
            r_beat  <= '0;
            r_addr  <= w_calc_addr;
            r_rem   <= w_calc_rem;
            r_axlen <= 8'(w_len - 9'd1);
            if (w_rem_next == '0) r_k <= '0;
          end
        end
        ST_RD_DATA: begin
          if (m_axi_rvalid) begin
            r_beat <= r_beat + 8'd1;
            r_k    <= r_k + 1'b1;
            if (w_mismatch && !r_fail) begin
              r_fail      <= 1'b1;
              r_fail_addr <= w_beat_addr;
            end
            if (m_axi_rlast) begin
              r_beat  <= '0;
              r_addr  <= w_calc_addr;
              r_rem   <= w_calc_rem;
              r_axlen <= 8'(w_len - 9'd1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign fail         = r_fail;
  assign fail_addr    = r_fail_addr;
  assign m_axi_awaddr = r_addr;
  assign m_axi_araddr = r_addr;
  assign m_axi_awlen  = r_axlen;
  assign m_axi_arlen  = r_axlen;
  assign m_axi_wdata  = w_expect;

endmodule
